// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch/sequencing stage: opcode values,
// instruction field positions, FSM state encoding and small decode helpers.
package fetch_unit_pkg;

    // Instruction field bit positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 8;

    // Opcodes of the 16-bit ISA
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_SUBI = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hE;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_ISSUE  = 2'd3
    } state_t;

    // Opcode field of an instruction word
    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    // Branch/jump target field of an instruction word
    function automatic logic [3:0] target_of(input logic [15:0] word);
        return word[TGT_MSB:TGT_LSB];
    endfunction

    // Opcodes resolved inside the fetch stage and never handed to execute
    function automatic logic is_local_op(input logic [3:0] op);
        return (op == OP_NOP) || (op == OP_JMP) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, the program ROM and the execute stage.
// master = fetch unit side, slave = ROM/execute side.
interface fetch_unit_if #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic [INST_W-1:0] inst;
    logic              inst_valid;
    logic              inst_ready;
    logic              zero_flag;

    modport master (
        output rom_addr,
        input  rom_data,
        output inst,
        output inst_valid,
        input  inst_ready,
        input  zero_flag
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  inst,
        input  inst_valid,
        output inst_ready,
        output zero_flag
    );
endinterface

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: taken jmp/br load the target field,
// everything else (including an untaken br) advances by one with wrap.
module next_pc_logic
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] ir,
    input  logic              zero_flag,
    output logic [ADDR_W-1:0] next_pc,
    output logic              taken
);

    logic [3:0]        op;
    logic [ADDR_W-1:0] target;

    // Decide between sequential advance and branch target
    always_comb begin
        op      = opcode_of(ir);
        target  = ADDR_W'(target_of(ir));
        taken   = (op == OP_JMP) || ((op == OP_BR) && zero_flag);
        next_pc = taken ? target : (pc + ADDR_W'(1));
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and sequencing stage. Owns the program counter and the
// instruction register, resolves nop/jmp/br locally and offers every other
// instruction to execute through a valid/ready handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    fetch_unit_if.master      bus,
    output logic [ADDR_W-1:0] pc,
    output logic              branch_taken
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] ir_q;
    logic [ADDR_W-1:0] next_pc;
    logic              taken;
    logic [3:0]        opcode;
    logic              ir_load;
    logic              pc_load;
    logic              valid_c;
    logic              taken_pulse;

    next_pc_logic #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_next_pc (
        .pc        (pc_q),
        .ir        (ir_q),
        .zero_flag (bus.zero_flag),
        .next_pc   (next_pc),
        .taken     (taken)
    );

    assign opcode = opcode_of(ir_q);

    // FSM state register; reset always lands in IDLE, even mid-handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        state_d     = state_q;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        valid_c     = 1'b0;
        taken_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_load = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // pc advances or jumps here, so during ISSUE rom_addr
                // already points at the following instruction
                pc_load     = 1'b1;
                taken_pulse = taken;
                state_d     = is_local_op(opcode) ? ST_FETCH : ST_ISSUE;
            end
            ST_ISSUE: begin
                valid_c = 1'b1;
                if (bus.inst_ready) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Program counter, wraps modulo 2^ADDR_W through next_pc_logic
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (pc_load) begin
            pc_q <= next_pc;
        end
    end

    // Instruction register; only written in FETCH so it is frozen while offered
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= '0;
        end else if (ir_load) begin
            ir_q <= bus.rom_data;
        end
    end

    assign bus.rom_addr   = pc_q;
    assign bus.inst       = ir_q;
    assign bus.inst_valid = valid_c;
    assign pc             = pc_q;
    assign branch_taken   = taken_pulse;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an instruction-level program walker predicts, per
// clock cycle, the ROM address, offered instruction and branch pulses.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int ADDR_W = 4;
    localparam int INST_W = 16;
    localparam int MAXC   = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              branch_taken;

    logic [15:0] rom [16];
    bit          ready_pat [MAXC];
    bit          zf_pat    [MAXC];
    bit          exp_valid [MAXC];
    bit          exp_bt    [MAXC];
    logic [3:0]  exp_addr  [MAXC];
    logic [15:0] exp_inst  [MAXC];

    int n_vec;
    int n_err;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .bus          (bus),
        .pc           (pc),
        .branch_taken (branch_taken)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic set_patterns(input bit rdy, input bit zf);
        for (int i = 0; i < MAXC; i++) begin
            ready_pat[i] = rdy;
            zf_pat[i]    = zf;
        end
    endtask

    // Walk the program one instruction at a time. Fetch cycle t, decode t+1;
    // local ops refetch at t+2, issued ops are offered from t+2 until the
    // first cycle with ready high. In dp_mode a tiny datapath (LOAD, SUBI set
    // Z) supplies the zero flag from the cycle after each transfer.
    task automatic build_expect(input int ncyc, input bit dp_mode);
        int          t;
        int          k;
        logic [3:0]  a;
        logic [3:0]  op;
        logic [3:0]  tgt;
        logic [3:0]  rd;
        logic [15:0] w;
        logic [15:0] regs [16];
        bit          tk;
        bit          z;
        for (int i = 0; i < MAXC; i++) begin
            exp_valid[i] = 0;
            exp_bt[i]    = 0;
            exp_addr[i]  = 4'h0;
            exp_inst[i]  = 16'h0;
            if (dp_mode) zf_pat[i] = 0;
        end
        for (int i = 0; i < 16; i++) regs[i] = 16'h0;
        z = 0;
        t = 0;
        a = 4'h0;
        while (t < ncyc) begin
            w   = rom[a];
            op  = w[15:12];
            tgt = w[11:8];
            exp_addr[t] = a;
            if (op == 4'h0 || op == 4'h8 || op == 4'hC) begin
                tk = (op == 4'h8) || (op == 4'hC && zf_pat[t+1]);
                exp_addr[t+1] = a;
                exp_bt[t+1]   = tk;
                a = tk ? tgt : a + 4'd1;
                t = t + 2;
            end else begin
                exp_addr[t+1] = a;
                a = a + 4'd1;
                k = t + 2;
                while (k < ncyc && !ready_pat[k]) begin
                    exp_valid[k] = 1;
                    exp_inst[k]  = w;
                    exp_addr[k]  = a;
                    k++;
                end
                if (k < ncyc) begin
                    exp_valid[k] = 1;
                    exp_inst[k]  = w;
                    exp_addr[k]  = a;
                    if (dp_mode) begin
                        rd = w[11:8];
                        if (op == 4'h1) begin
                            regs[rd] = {8'h00, w[7:0]};
                            z = (regs[rd] == 16'h0);
                        end else if (op == 4'hB) begin
                            regs[rd] = regs[rd] - {8'h00, w[7:0]};
                            z = (regs[rd] == 16'h0);
                        end
                        for (int j = k + 1; j < MAXC; j++) zf_pat[j] = z;
                    end
                end
                t = k + 1;
            end
        end
    endtask

    // Reset, hold run low for 5 idle cycles, start and check ncyc cycles.
    task automatic scenario(input int ncyc, input bit dp_mode, input int n_out_exp);
        int n_out;
        build_expect(ncyc, dp_mode);
        rst = 1'b1;
        run = 1'b0;
        bus.inst_ready = 1'b0;
        bus.zero_flag  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_valid", bus.inst_valid, 0);
            chk("idle_pc", pc, 0);
            chk("idle_inst", bus.inst, 0);
            chk("idle_bt", branch_taken, 0);
        end
        run = 1'b1;
        n_out = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            bus.inst_ready = ready_pat[k];
            bus.zero_flag  = zf_pat[k];
            run            = 1'($urandom);
            @(negedge clk);
            chk("rom_addr", bus.rom_addr, exp_addr[k]);
            chk("pc", pc, exp_addr[k]);
            chk("inst_valid", bus.inst_valid, exp_valid[k]);
            chk("branch_taken", branch_taken, exp_bt[k]);
            if (exp_valid[k]) chk("inst", bus.inst, exp_inst[k]);
            if (bus.inst_valid && bus.inst_ready && bus.inst[15:12] == 4'hE) n_out++;
        end
        if (n_out_exp >= 0) chk("out_issues", n_out, n_out_exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        run   = 1'b0;
        bus.inst_ready = 1'b0;
        bus.zero_flag  = 1'b0;

        // Straight-line issue followed by nop -> jmp 7 -> jmp 3 loop
        clear_rom();
        rom[0] = 16'h1E0F;
        rom[1] = 16'h1201;
        rom[2] = 16'hB401;
        rom[3] = 16'h0000;
        rom[4] = 16'h8700;
        rom[7] = 16'h8300;
        set_patterns(1, 0);
        scenario(40, 0, -1);

        // Same program, execute stalls 4 cycles on the second instruction
        set_patterns(1, 0);
        for (int i = 5; i <= 8; i++) ready_pat[i] = 0;
        scenario(40, 0, -1);

        // br at 6: untaken on first visit, taken once Z rises
        clear_rom();
        rom[0]  = 16'h8600;
        rom[6]  = 16'hCA00;
        rom[7]  = 16'h8000;
        rom[10] = 16'h8A00;
        set_patterns(1, 0);
        for (int i = 8; i < MAXC; i++) zf_pat[i] = 1;
        scenario(30, 0, -1);

        // Decrement loop: 15 x (out r7; subi r1,1; br 10; jmp 4)
        clear_rom();
        rom[0]  = 16'h110F;
        rom[1]  = 16'h8400;
        rom[4]  = 16'hE700;
        rom[5]  = 16'hB101;
        rom[6]  = 16'hCA00;
        rom[7]  = 16'h8400;
        rom[10] = 16'h8A00;
        set_patterns(1, 0);
        scenario(180, 1, 15);

        // pc wrap 15 -> 0, then reset while an instruction is offered
        clear_rom();
        rom[0]  = 16'h8F00;
        rom[15] = 16'h2345;
        set_patterns(0, 0);
        for (int i = 0; i < 20; i++) ready_pat[i] = 1;
        scenario(26, 0, -1);
        chk("pre_rst_valid", bus.inst_valid, 1);
        rst = 1'b1;
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.inst_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_bt", branch_taken, 0);
        rst = 1'b0;

        // Randomized programs, backpressure and zero flag
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 8))
                    0: rom[i] = {4'h0, 12'($urandom)};
                    1: rom[i] = {4'h8, 12'($urandom)};
                    2: rom[i] = {4'hC, 12'($urandom)};
                    3: rom[i] = {4'h1, 12'($urandom)};
                    4: rom[i] = {4'h2, 12'($urandom)};
                    5: rom[i] = {4'h3, 12'($urandom)};
                    6: rom[i] = {4'h4, 12'($urandom)};
                    7: rom[i] = {4'hB, 12'($urandom)};
                    default: rom[i] = {4'hE, 12'($urandom)};
                endcase
            end
            for (int i = 0; i < MAXC; i++) begin
                ready_pat[i] = ($urandom_range(0, 3) != 0);
                zf_pat[i]    = 1'($urandom);
            end
            scenario(200, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
